// File: rtl/traffic_phase_fsm_if.sv
// ============================================================================
// Module   : traffic_phase_fsm_if
// Brief    : Tick/sensor inputs and phase outputs of the intersection sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface traffic_phase_fsm_if;
   logic       tick;
   logic [3:0] sensor;
   logic [3:0] light_signal;
   logic [1:0] active_lane;

   modport master (
      output tick,
      output sensor,
      input  light_signal,
      input  active_lane
   );

   modport slave (
      input  tick,
      input  sensor,
      output light_signal,
      output active_lane
   );
endinterface

`default_nettype wire

// File: rtl/traffic_phase_fsm.sv
// ============================================================================
// Module   : traffic_phase_fsm
// Brief    : Round-robin, demand-skipping phase sequencer with min/max green.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_phase_fsm #(
   parameter int GREEN_MIN   = 10,
   parameter int GREEN_MAX   = 30,
   parameter int YELLOW_TIME = 3,
   parameter int CNT_W       = 8
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   traffic_phase_fsm_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_ALL_RED = 2'd0,
      ST_GREEN   = 2'd1,
      ST_YELLOW  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       lane_q, lane_d;
   logic [1:0]       last_lane_q, last_lane_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic [3:0]       sync1_q;
   logic [3:0]       sens_s_q;
   logic [3:0]       light_q, light_d;
   logic [1:0]       cand;
   logic             found;

   assign cnt_inc = cnt_q + CNT_W'(1);

   always_comb begin
      state_d     = state_q;
      lane_d      = lane_q;
      last_lane_d = last_lane_q;
      cnt_d       = cnt_q;
      found       = 1'b0;
      cand        = 2'd0;
      if (bus.tick) begin
         unique case (state_q)
            ST_ALL_RED: begin
               // Offset 4 wraps to last_lane itself, so a lone repeat demand is still served.
               for (int i = 1; i <= 4; i++) begin
                  cand = last_lane_q + 2'(i);
                  if (!found && sens_s_q[cand]) begin
                     found       = 1'b1;
                     lane_d      = cand;
                     last_lane_d = cand;
                     state_d     = ST_GREEN;
                     cnt_d       = '0;
                  end
               end
            end
            ST_GREEN: begin
               if ((cnt_inc >= CNT_W'(GREEN_MAX)) ||
                   ((cnt_inc >= CNT_W'(GREEN_MIN)) && !sens_s_q[lane_q])) begin
                  state_d = ST_YELLOW;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            ST_YELLOW: begin
               if (cnt_inc >= CNT_W'(YELLOW_TIME)) begin
                  state_d = ST_ALL_RED;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               state_d = ST_ALL_RED;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Phase code is derived from the next state so the output register tracks state with no extra lag.
   always_comb begin
      light_d = 4'd0;
      unique case (state_d)
         ST_GREEN:  light_d = {1'b0, lane_d, 1'b1};
         ST_YELLOW: light_d = {1'b0, lane_d, 1'b0} + 4'd2;
         default:   light_d = 4'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ALL_RED;
         lane_q      <= 2'd0;
         last_lane_q <= 2'd3;
         cnt_q       <= '0;
         sync1_q     <= 4'd0;
         sens_s_q    <= 4'd0;
         light_q     <= 4'd0;
      end else begin
         state_q     <= state_d;
         lane_q      <= lane_d;
         last_lane_q <= last_lane_d;
         cnt_q       <= cnt_d;
         sync1_q     <= bus.sensor;
         sens_s_q    <= sync1_q;
         light_q     <= light_d;
      end
   end

   assign bus.light_signal = light_q;
   assign bus.active_lane  = lane_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_fsm.sv
// ============================================================================
// Module   : tb_traffic_phase_fsm
// Brief    : Directed and random bench for traffic_phase_fsm with a phase-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_traffic_phase_fsm;
   localparam int GMIN = 4;
   localparam int GMAX = 8;
   localparam int YT   = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   traffic_phase_fsm_if bus_if ();

   traffic_phase_fsm #(
      .GREEN_MIN   (GMIN),
      .GREEN_MAX   (GMAX),
      .YELLOW_TIME (YT),
      .CNT_W       (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: the displayed phase code, the lane, the lane last granted, ticks spent in phase.
   int         m_code, m_lane, m_last, m_dwell;
   logic [3:0] p1, p2;
   int         exp_code[$];
   int         exp_dwell[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_code  = 0;
      m_lane  = 0;
      m_last  = 3;
      m_dwell = 0;
      p1      = 4'd0;
      p2      = 4'd0;
   endtask

   // p2 is the demand vector as the sequencer sees it: sensor sampled two edges ago.
   task automatic model_edge();
      if (bus_if.tick) begin
         if (m_code == 0) begin
            for (int k = 1; k <= 4; k++) begin
               int l;
               l = (m_last + k) % 4;
               if (p2[l]) begin
                  m_lane  = l;
                  m_last  = l;
                  m_code  = 2 * l + 1;
                  m_dwell = 0;
                  break;
               end
            end
         end else if (m_code % 2 == 1) begin
            m_dwell++;
            if (m_dwell >= GMAX || (m_dwell >= GMIN && !p2[m_lane])) begin
               m_code  = 2 * m_lane + 2;
               m_dwell = 0;
            end
         end else begin
            m_dwell++;
            if (m_dwell >= YT) begin
               m_code  = 0;
               m_dwell = 0;
            end
         end
      end
      p2 = p1;
      p1 = bus_if.sensor;
   endtask

   task automatic step(input bit t);
      bus_if.tick = t;
      @(posedge clk);
      if (rst_n) model_edge();
      else       model_reset();
      #1;
      chk("light", bus_if.light_signal, m_code);
      chk("lane", bus_if.active_lane, m_lane);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_light", bus_if.light_signal, 0);
      chk("rst_lane", bus_if.active_lane, 0);
      model_reset();
      step(1);
      step(1);
      rst_n = 1'b1;
   endtask

   task automatic wait_code(input string tag, input int code);
      int g;
      g = 0;
      while (bus_if.light_signal !== code[3:0] && g < 40) begin
         step(1);
         g++;
      end
      chk(tag, bus_if.light_signal, code);
   endtask

   task automatic check_runs(input string tag);
      int n;
      wait_code({tag, "_first"}, exp_code[0]);
      for (int i = 0; i < exp_code.size(); i++) begin
         if (i > 0) chk({tag, "_code"}, bus_if.light_signal, exp_code[i]);
         if (exp_dwell[i] == 0) break;
         n = 1;
         step(1);
         while (bus_if.light_signal === exp_code[i][3:0] && n < 100) begin
            n++;
            step(1);
         end
         chk({tag, "_dwell"}, n, exp_dwell[i]);
      end
      exp_code.delete();
      exp_dwell.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus_if.tick   = 1'b0;
      bus_if.sensor = 4'd0;
      model_reset();
      @(posedge clk);
      #1;

      // No demand: all red, lane 0
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step(1);
         chk("t1_light", bus_if.light_signal, 0);
         chk("t1_lane", bus_if.active_lane, 0);
      end

      // Single lane held: max green, yellow, one-tick clearance, repeat
      do_reset();
      bus_if.sensor = 4'b0001;
      exp_code  = '{1, 2, 0, 1, 2, 0, 1};
      exp_dwell = '{8, 2, 1, 8, 2, 1, 0};
      check_runs("t2");

      // Demand dropped early: green ends at minimum
      do_reset();
      bus_if.sensor = 4'b0001;
      wait_code("t3_first", 1);
      step(1);
      bus_if.sensor = 4'b0000;
      n = 2;
      step(1);
      while (bus_if.light_signal === 4'd1 && n < 100) begin
         n++;
         step(1);
      end
      chk("t3_green_dwell", n, GMIN);
      chk("t3_yellow", bus_if.light_signal, 2);
      step(1);
      step(1);
      for (int i = 0; i < 5; i++) begin
         chk("t3_red", bus_if.light_signal, 0);
         step(1);
      end

      // All lanes demanding: full rotation
      do_reset();
      bus_if.sensor = 4'b1111;
      exp_code  = '{1, 2, 0, 3, 4, 0, 5, 6, 0, 7, 8, 0, 1};
      exp_dwell = '{8, 2, 1, 8, 2, 1, 8, 2, 1, 8, 2, 1, 0};
      check_runs("t4");
      chk("t4_lane_wrap", bus_if.active_lane, 0);

      // Lanes 1 and 3 only: idle lanes skipped
      do_reset();
      bus_if.sensor = 4'b1010;
      exp_code  = '{3, 4, 0, 7, 8, 0, 3};
      exp_dwell = '{8, 2, 1, 8, 2, 1, 0};
      check_runs("t5");

      // Reset in mid-green forces all red at once
      do_reset();
      bus_if.sensor = 4'b0010;
      wait_code("t6_first", 3);
      for (int i = 0; i < 4; i++) step(1);
      chk("t6_pre_rst", bus_if.light_signal, 3);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_light", bus_if.light_signal, 0);
      chk("t6_rst_lane", bus_if.active_lane, 0);
      model_reset();
      step(1);
      step(1);
      rst_n = 1'b1;
      step(1);
      chk("t6_sync1", bus_if.light_signal, 0);
      step(1);
      chk("t6_sync2", bus_if.light_signal, 0);
      step(1);
      chk("t6_regreen", bus_if.light_signal, 3);
      chk("t6_lane", bus_if.active_lane, 1);

      // Random demand, sparse ticks, occasional reset
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) bus_if.sensor = 4'($urandom);
         if ($urandom_range(0, 499) == 0) begin
            rst_n = 1'b0;
            #1;
            chk("rnd_rst_light", bus_if.light_signal, 0);
            model_reset();
            step(1);
            rst_n = 1'b1;
         end
         step($urandom_range(0, 3) != 0);
         chk("rnd_code_range", (bus_if.light_signal <= 4'd8), 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/traffic_phase_fsm.md
# traffic_phase_fsm

Adaptive phase sequencer for the four-lane intersection. It sits directly upstream of the traffic light driver and produces the 4-bit phase code on `light_signal` that the driver decodes into per-lane lamp outputs. It serves lanes round-robin, skips lanes with no demand, and extends green while demand persists, bounded by minimum and maximum green times. All timing is counted in ticks of an external time-base strobe.

## Interface
- `GREEN_MIN`, default 10: minimum green duration, in ticks (≥1).
- `GREEN_MAX`, default 30: maximum green duration, in ticks (≥ `GREEN_MIN`).
- `YELLOW_TIME`, default 3: yellow duration, in ticks (≥1).
- `CNT_W`, default 8: tick counter width; must hold `GREEN_MAX`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `tick`  in  1  time-base strobe, one cycle wide, synchronous to `clk`.
- `sensor`  in  4  vehicle demand, asynchronous. Bit0 = NS1, bit1 = NS2, bit2 = EW1, bit3 = EW2.
- `light_signal`  out  4  phase code to the driver:
  - 0 = all red.
  - 2L+1 = green for lane L.
  - 2L+2 = yellow for lane L.
- `active_lane`  out  2  lane currently or last served.

## Operation
- `sensor` passes through a 2-flop synchronizer per bit; `sens_s` is the synchronized value. All decisions use `sens_s`.
- States:
  - ALL_RED: `light_signal` = 0.
  - GREEN: `light_signal` = 2L+1.
  - YELLOW: `light_signal` = 2L+2.
- Registers: `state`, `lane[1:0]`, `last_lane[1:0]`, `cnt[CNT_W-1:0]`.
- Decisions happen only on cycles with `tick`=1. Without `tick`, nothing changes except the synchronizer.
- ALL_RED on tick:
  - Search lanes `last_lane`+1, +2, +3, +4 (mod 4) for the first one with `sens_s` set.
  - If found: go to GREEN, set `lane` = that lane and `last_lane` = that lane, set `cnt` = 0.
  - If none found: stay in ALL_RED.
  - A lone demanding lane equal to `last_lane` is re-selected, because the search wraps around to it.
- GREEN on tick, with e = `cnt`+1:
  - If e ≥ `GREEN_MAX`, or (e ≥ `GREEN_MIN` and `sens_s[lane]`=0): go to YELLOW, set `cnt` = 0.
  - Otherwise set `cnt` = e.
  - Demand on other lanes does not shorten green.
- YELLOW on tick, with e = `cnt`+1:
  - If e ≥ `YELLOW_TIME`: go to ALL_RED, set `cnt` = 0.
  - Otherwise set `cnt` = e.
- ALL_RED always lasts at least 1 tick (clearance) between any yellow and the next green.
- Green lasts between `GREEN_MIN` and `GREEN_MAX` ticks. Yellow lasts exactly `YELLOW_TIME` ticks.
- `active_lane` = `lane`. It holds its value through YELLOW and ALL_RED.
- Codes 9–15 are never produced.

## Timing
- Reset values (asynchronous on `rst_n`=0):
  - `state` = ALL_RED, `light_signal` = 0.
  - `lane` = 0, `active_lane` = 0.
  - `last_lane` = 3, so the first search starts at lane 0.
  - `cnt` = 0, synchronizer flops = 0.
- Reset mid-phase forces `light_signal` to 0 immediately, with no yellow.
- Reset release: the first decision happens on the first tick after release.
- All outputs are registered and change on the `clk` edge where `tick`=1 is sampled. Latency from tick to output is 1 cycle.
- `sensor` latency is 2 clocks. A `sensor` change must be stable 2 clocks before a tick to affect that tick's decision. A change arriving with or within 1 clock of a tick is evaluated at the next tick.
- `tick` asserted continuously: every cycle counts as a tick. Legal; used by benches for speed.

## Test plan
Tests 2–6 use `GREEN_MIN`=4, `GREEN_MAX`=8, `YELLOW_TIME`=2, with `tick` every cycle.

1. Reset with `sensor`=0, run 20 ticks → `light_signal` stays 0 and `active_lane` stays 0 throughout.
2. `sensor`=4'b0001 held → code 1 for 8 ticks, code 2 for 2 ticks, code 0 for 1 tick, then code 1 again (repeating).
3. `sensor`=4'b0001, dropped after the 2nd green tick → green ends after exactly 4 ticks (min), then 2, 2, 0.
4. `sensor`=4'b1111 held → code sequence 1,2,0,3,4,0,5,6,0,7,8,0,1 with dwell times 8/2/1 each. `active_lane` steps 0,1,2,3,0.
5. `sensor`=4'b1010 held → code sequence 3,4,0,7,8,0,3. Lanes 0 and 2 are never served.
6. Assert `rst_n`=0 on the 5th green tick of lane 1 → `light_signal`=0 in the same cycle. After release with `sensor`=4'b0010, lane 1 is served; the search starts from lane 0.
